// File: rtl/cmem_port_arbiter.sv
// ============================================================================
// cmem_port_arbiter - round-robin share of the cmem SPI nibble port (2 requesters)
// Optional grant lock with idle timeout: define CMEM_ARB_LOCK_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module cmem_port_arbiter #(
    parameter logic RR_INIT  = 1'b0,
    parameter int   LOCK_MAX = 64,
    parameter int   LOCK_W   = 7
) (
    input  logic       clk200,
    input  logic       reset,
    input  logic       r0_req_valid,
    input  logic       r0_req_write,
    input  logic [3:0] r0_req_addr,
    input  logic [3:0] r0_req_wdata,
    input  logic       r0_req_lock,
    output logic       r0_req_ready,
    output logic       r0_resp_valid,
    output logic [3:0] r0_resp_rdata,
    input  logic       r1_req_valid,
    input  logic       r1_req_write,
    input  logic [3:0] r1_req_addr,
    input  logic [3:0] r1_req_wdata,
    input  logic       r1_req_lock,
    output logic       r1_req_ready,
    output logic       r1_resp_valid,
    output logic [3:0] r1_resp_rdata,
    output logic       cmem_read,
    output logic       cmem_write,
    output logic [3:0] cmem_address,
    output logic [3:0] cmem_wdata,
    input  logic [3:0] cmem_rdata,
    output logic       lock_timeout
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic       prio_q, prio_d;
    logic       id_q, id_d;
    logic       wr_q, wr_d;
    logic [3:0] addr_q, addr_d;
    logic [3:0] wdata_q, wdata_d;
    logic [3:0] rdata_q, rdata_d;
    logic       rd_stb_q, rd_stb_d;
    logic       wr_stb_q, wr_stb_d;
    logic       resp0_q, resp0_d;
    logic       resp1_q, resp1_d;

    logic       w_held;
    logic       w_held_id;
    logic       w_elig0;
    logic       w_elig1;
    logic       w_win_valid;
    logic       w_win_id;
    logic       w_win_lock;
    logic       w_accept;

    // A held lock masks the other requester out of arbitration entirely.
    assign w_elig0      = r0_req_valid && (!w_held || !w_held_id);
    assign w_elig1      = r1_req_valid && (!w_held || w_held_id);
    assign w_win_valid  = w_elig0 || w_elig1;
    assign w_win_id     = (w_elig0 && w_elig1) ? prio_q : w_elig1;
    assign w_win_lock   = w_win_id ? r1_req_lock : r0_req_lock;
    assign w_accept     = (state_q == S_IDLE) && w_win_valid;

    assign r0_req_ready  = w_accept && !w_win_id;
    assign r1_req_ready  = w_accept && w_win_id;
    assign cmem_read     = rd_stb_q;
    assign cmem_write    = wr_stb_q;
    assign cmem_address  = addr_q;
    assign cmem_wdata    = wdata_q;
    assign r0_resp_valid = resp0_q;
    assign r1_resp_valid = resp1_q;
    assign r0_resp_rdata = rdata_q;
    assign r1_resp_rdata = rdata_q;

    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        id_d     = id_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        rd_stb_d = 1'b0;
        wr_stb_d = 1'b0;
        resp0_d  = 1'b0;
        resp1_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_win_valid) begin
                    id_d     = w_win_id;
                    wr_d     = w_win_id ? r1_req_write : r0_req_write;
                    addr_d   = w_win_id ? r1_req_addr  : r0_req_addr;
                    wdata_d  = w_win_id ? r1_req_wdata : r0_req_wdata;
                    rd_stb_d = !wr_d;
                    wr_stb_d = wr_d;
                    if (!w_held) begin
                        prio_d = ~w_win_id;
                    end
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                // cmem registers its read data on the strobe edge, so it is valid here.
                rdata_d = wr_q ? 4'h0 : cmem_rdata;
                resp0_d = !id_q;
                resp1_d = id_q;
                state_d = S_RESP;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk200 or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            prio_q   <= RR_INIT;
            id_q     <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= 4'h0;
            wdata_q  <= 4'h0;
            rdata_q  <= 4'h0;
            rd_stb_q <= 1'b0;
            wr_stb_q <= 1'b0;
            resp0_q  <= 1'b0;
            resp1_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            id_q     <= id_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            rd_stb_q <= rd_stb_d;
            wr_stb_q <= wr_stb_d;
            resp0_q  <= resp0_d;
            resp1_q  <= resp1_d;
        end
    end

`ifdef CMEM_ARB_LOCK_EN
    logic              held_q, held_d;
    logic              held_id_q, held_id_d;
    logic              tmo_q, tmo_d;
    logic [LOCK_W-1:0] idle_cnt_q, idle_cnt_d;

    assign w_held       = held_q;
    assign w_held_id    = held_id_q;
    assign lock_timeout = tmo_q;

    always_comb begin
        held_d     = held_q;
        held_id_d  = held_id_q;
        idle_cnt_d = idle_cnt_q;
        tmo_d      = 1'b0;
        if (w_accept) begin
            idle_cnt_d = '0;
            held_d     = w_win_lock;
            held_id_d  = w_win_id;
        end else if ((state_q == S_IDLE) && held_q) begin
            // No accept while held means the holder is not requesting this cycle.
            if (idle_cnt_q == LOCK_W'(LOCK_MAX - 1)) begin
                held_d     = 1'b0;
                idle_cnt_d = '0;
                tmo_d      = 1'b1;
            end else begin
                idle_cnt_d = idle_cnt_q + LOCK_W'(1);
            end
        end
    end

    always_ff @(posedge clk200 or posedge reset) begin
        if (reset) begin
            held_q     <= 1'b0;
            held_id_q  <= 1'b0;
            tmo_q      <= 1'b0;
            idle_cnt_q <= '0;
        end else begin
            held_q     <= held_d;
            held_id_q  <= held_id_d;
            tmo_q      <= tmo_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end
`else
    logic [LOCK_W:0] w_cfg_unused;

    assign w_held       = 1'b0;
    assign w_held_id    = 1'b0;
    assign lock_timeout = 1'b0;
    assign w_cfg_unused = {w_win_lock, LOCK_W'(LOCK_MAX)};
`endif

endmodule

`default_nettype wire

// File: tb/tb_cmem_port_arbiter.sv
// ============================================================================
// tb_cmem_port_arbiter - directed scoreboard bench for cmem_port_arbiter
// Lock scenarios follow CMEM_ARB_LOCK_EN when defined.   Rev 1.0
// ============================================================================
`default_nettype none

module tb_cmem_port_arbiter;

`ifdef CMEM_ARB_LOCK_EN
    localparam int T5_R1_K  = 2;
    localparam int T6_RDY_K = 66;
    localparam int T6_TMO_N = 1;
`else
    localparam int T5_R1_K  = 1;
    localparam int T6_RDY_K = 2;
    localparam int T6_TMO_N = 0;
`endif

    logic       clk200 = 1'b0;
    logic       reset;
    logic       r0_req_valid, r0_req_write, r0_req_lock;
    logic [3:0] r0_req_addr, r0_req_wdata;
    logic       r0_req_ready, r0_resp_valid;
    logic [3:0] r0_resp_rdata;
    logic       r1_req_valid, r1_req_write, r1_req_lock;
    logic [3:0] r1_req_addr, r1_req_wdata;
    logic       r1_req_ready, r1_resp_valid;
    logic [3:0] r1_resp_rdata;
    logic       cmem_read, cmem_write;
    logic [3:0] cmem_address, cmem_wdata, cmem_rdata;
    logic       lock_timeout;

    logic       mem_load;
    logic [3:0] mem     [16];
    logic [3:0] exp_mem [16];

    typedef struct packed {
        logic       id;
        logic [3:0] rdata;
    } resp_t;

    resp_t sb_q [$];
    resp_t mon_e;
    int    n_vec = 0;
    int    n_err = 0;

    always #5 clk200 = ~clk200;

    cmem_port_arbiter dut (
        .clk200        (clk200),
        .reset         (reset),
        .r0_req_valid  (r0_req_valid),
        .r0_req_write  (r0_req_write),
        .r0_req_addr   (r0_req_addr),
        .r0_req_wdata  (r0_req_wdata),
        .r0_req_lock   (r0_req_lock),
        .r0_req_ready  (r0_req_ready),
        .r0_resp_valid (r0_resp_valid),
        .r0_resp_rdata (r0_resp_rdata),
        .r1_req_valid  (r1_req_valid),
        .r1_req_write  (r1_req_write),
        .r1_req_addr   (r1_req_addr),
        .r1_req_wdata  (r1_req_wdata),
        .r1_req_lock   (r1_req_lock),
        .r1_req_ready  (r1_req_ready),
        .r1_resp_valid (r1_resp_valid),
        .r1_resp_rdata (r1_resp_rdata),
        .cmem_read     (cmem_read),
        .cmem_write    (cmem_write),
        .cmem_address  (cmem_address),
        .cmem_wdata    (cmem_wdata),
        .cmem_rdata    (cmem_rdata),
        .lock_timeout  (lock_timeout)
    );

    // Behavioural cmem: registered read data, write on strobe.
    always @(posedge clk200) begin
        if (mem_load) begin
            for (int i = 0; i < 16; i++) mem[i] <= 4'(i * 7 + 4);
            cmem_rdata <= 4'h0;
        end else begin
            if (cmem_write) mem[cmem_address] <= cmem_wdata;
            if (cmem_read)  cmem_rdata <= mem[cmem_address];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input bit id, input logic v, input logic w,
                           input logic [3:0] a, input logic [3:0] d, input logic lk);
        if (id) begin
            r1_req_valid = v; r1_req_write = w; r1_req_addr = a; r1_req_wdata = d; r1_req_lock = lk;
        end else begin
            r0_req_valid = v; r0_req_write = w; r0_req_addr = a; r0_req_wdata = d; r0_req_lock = lk;
        end
    endtask

    function automatic logic ready_of(input bit id);
        return id ? r1_req_ready : r0_req_ready;
    endfunction

    task automatic expect_resp(input bit id, input logic w, input logic [3:0] a, input logic [3:0] d);
        resp_t e;
        e.id    = id;
        e.rdata = w ? 4'h0 : exp_mem[a];
        sb_q.push_back(e);
        if (w) exp_mem[a] = d;
    endtask

    task automatic wait_ready(input bit id, input int max, output int k);
        k = 0;
        #1;
        while (ready_of(id) !== 1'b1 && k < max) begin
            @(negedge clk200);
            #1;
            k++;
        end
    endtask

    // Returns at the negedge of the CAPTURE cycle.
    task automatic access(input bit id, input logic w, input logic [3:0] a,
                          input logic [3:0] d, input logic lk, input string tag);
        int k;
        @(negedge clk200);
        set_req(id, 1'b1, w, a, d, lk);
        wait_ready(id, 40, k);
        check({tag, "_ready"}, 32'(ready_of(id)), 32'd1);
        if (ready_of(id) === 1'b1) expect_resp(id, w, a, d);
        @(negedge clk200);
        set_req(id, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        check({tag, "_strobe"}, {30'd0, cmem_write, cmem_read}, w ? 32'd2 : 32'd1);
        check({tag, "_addr"}, 32'(cmem_address), 32'(a));
        if (w) check({tag, "_wdata"}, 32'(cmem_wdata), 32'(d));
        @(negedge clk200);
        check({tag, "_strobe_off"}, {30'd0, cmem_write, cmem_read}, 32'd0);
    endtask

    // Response scoreboard and single-grant monitor.
    always begin
        @(negedge clk200);
        #2;
        if (reset !== 1'b1) begin
            if (r0_resp_valid === 1'b1 || r1_resp_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_resp", {30'd0, r1_resp_valid, r0_resp_valid}, 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("resp_id", {30'd0, r1_resp_valid, r0_resp_valid}, mon_e.id ? 32'd2 : 32'd1);
                    check("resp_rdata", 32'(mon_e.id ? r1_resp_rdata : r0_resp_rdata), 32'(mon_e.rdata));
                end
            end
            if (r0_req_valid === 1'b1 && r1_req_valid === 1'b1)
                check("double_ready", 32'(r0_req_ready & r1_req_ready), 32'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  k, grants, last, cyc, tmo_at, tmo_n, rdy_at;
        bit  exp_id;
        bit  blocked_seen;

        reset    = 1'b1;
        mem_load = 1'b1;
        set_req(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        set_req(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        for (int i = 0; i < 16; i++) exp_mem[i] = 4'(i * 7 + 4);
        repeat (3) @(negedge clk200);

        check("rst_strobes", {30'd0, cmem_write, cmem_read}, 32'd0);
        check("rst_addr_wdata", {24'd0, cmem_address, cmem_wdata}, 32'd0);
        check("rst_resp_tmo", {29'd0, r1_resp_valid, r0_resp_valid, lock_timeout}, 32'd0);
        check("rst_rdata", {24'd0, r1_resp_rdata, r0_resp_rdata}, 32'd0);
        mem_load = 1'b0;
        reset    = 1'b0;

        // Round robin with both requesting continuously.
        @(negedge clk200);
        set_req(1'b0, 1'b1, 1'b0, 4'h3, 4'h0, 1'b0);
        set_req(1'b1, 1'b1, 1'b0, 4'h7, 4'h0, 1'b0);
        grants = 0; last = -1; cyc = 0; exp_id = 1'b0;
        while (grants < 4 && cyc < 40) begin
            #1;
            if (r0_req_ready === 1'b1 || r1_req_ready === 1'b1) begin
                check("rr_order", {30'd0, r1_req_ready, r0_req_ready}, exp_id ? 32'd2 : 32'd1);
                if (last >= 0) check("rr_gap", 32'(cyc - last), 32'd4);
                expect_resp(r1_req_ready, 1'b0, r1_req_ready ? 4'h7 : 4'h3, 4'h0);
                last   = cyc;
                grants = grants + 1;
                exp_id = ~exp_id;
            end
            @(negedge clk200);
            cyc = cyc + 1;
        end
        check("rr_grants", 32'(grants), 32'd4);
        set_req(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        set_req(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        repeat (4) @(negedge clk200);

        // Single read of address B, response three cycles after accept.
        access(1'b0, 1'b0, 4'hB, 4'h0, 1'b0, "t1");
        @(negedge clk200);
        check("t1_latency", {30'd0, r1_resp_valid, r0_resp_valid}, 32'd1);
        check("t1_rdata", 32'(r0_resp_rdata), 32'h1);

        // r1 write, then read back through r0.
        access(1'b1, 1'b1, 4'hE, 4'h2, 1'b0, "t3");
        @(negedge clk200);
        check("t3_resp", {30'd0, r1_resp_valid, r0_resp_valid}, 32'd2);
        check("t3_rdata", 32'(r1_resp_rdata), 32'h0);
        access(1'b0, 1'b0, 4'hE, 4'h0, 1'b0, "t3rb");

        // Reset during ISSUE abandons the access; priority returns to RR_INIT.
        @(negedge clk200);
        set_req(1'b0, 1'b1, 1'b0, 4'h5, 4'h0, 1'b0);
        wait_ready(1'b0, 40, k);
        check("t4_ready", 32'(r0_req_ready), 32'd1);
        @(negedge clk200);
        set_req(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        check("t4_issue", 32'(cmem_read), 32'd1);
        #1 reset = 1'b1;
        #1 check("t4_async_clear", {30'd0, cmem_write, cmem_read}, 32'd0);
        repeat (2) @(negedge clk200);
        reset = 1'b0;
        set_req(1'b0, 1'b1, 1'b0, 4'h6, 4'h0, 1'b0);
        set_req(1'b1, 1'b1, 1'b0, 4'h9, 4'h0, 1'b0);
        #1;
        check("t4_grant_after_reset", {30'd0, r1_req_ready, r0_req_ready}, 32'd1);
        if (r0_req_ready === 1'b1) expect_resp(1'b0, 1'b0, 4'h6, 4'h0);
        if (r1_req_ready === 1'b1) expect_resp(1'b1, 1'b0, 4'h9, 4'h0);
        @(negedge clk200);
        set_req(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        set_req(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        repeat (5) @(negedge clk200);

        // Lock held by r0 blocks r1 until r0 releases it.
        access(1'b0, 1'b0, 4'h1, 4'h0, 1'b1, "t5_lock");
        @(negedge clk200);
        set_req(1'b1, 1'b1, 1'b0, 4'h2, 4'h0, 1'b0);
`ifdef CMEM_ARB_LOCK_EN
        blocked_seen = 1'b0;
        repeat (8) begin
            #1;
            if (r1_req_ready === 1'b1) blocked_seen = 1'b1;
            @(negedge clk200);
        end
        check("t5_r1_blocked", 32'(blocked_seen), 32'd0);
        access(1'b0, 1'b0, 4'h3, 4'h0, 1'b0, "t5_unlock");
`endif
        wait_ready(1'b1, 20, k);
        check("t5_r1_grant_k", 32'(k), 32'(T5_R1_K));
        if (r1_req_ready === 1'b1) expect_resp(1'b1, 1'b0, 4'h2, 4'h0);
        @(negedge clk200);
        set_req(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        repeat (4) @(negedge clk200);

        // Lock left idle is force-released after LOCK_MAX idle cycles.
        access(1'b0, 1'b0, 4'h4, 4'h0, 1'b1, "t6_lock");
        set_req(1'b1, 1'b1, 1'b0, 4'h8, 4'h0, 1'b0);
        tmo_at = -1; tmo_n = 0; rdy_at = -1;
        for (int kk = 1; kk <= 80; kk++) begin
            @(negedge clk200);
            #1;
            if (lock_timeout === 1'b1) begin
                tmo_n = tmo_n + 1;
                if (tmo_at < 0) tmo_at = kk;
            end
            if (rdy_at < 0 && r1_req_ready === 1'b1) begin
                rdy_at = kk;
                expect_resp(1'b1, 1'b0, 4'h8, 4'h0);
            end else if (rdy_at >= 0 && rdy_at == kk - 1) begin
                set_req(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
            end
        end
        check("t6_r1_grant_k", 32'(rdy_at), 32'(T6_RDY_K));
        check("t6_tmo_pulses", 32'(tmo_n), 32'(T6_TMO_N));
`ifdef CMEM_ARB_LOCK_EN
        check("t6_tmo_k", 32'(tmo_at), 32'(T6_RDY_K));
`endif

        repeat (6) @(negedge clk200);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
